// File: rtl/lsu_pkg.sv
// Shared load/store definitions: sequencer state encoding, access mask constants
// used by the decoder, and the lane-enable helper.
package lsu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ACC0 = S_ACC0,
        ST_ACC1 = S_ACC1,
        ST_RESP = S_RESP
    } lsu_state_e;

    localparam logic [4:0] MASK_B  = 5'b00001;
    localparam logic [4:0] MASK_H  = 5'b00011;
    localparam logic [4:0] MASK_W  = 5'b01111;
    localparam logic [4:0] MASK_BU = 5'b10001;
    localparam logic [4:0] MASK_HU = 5'b10011;

    // Byte lanes touched across two consecutive words; bits 7:4 belong to the next word.
    function automatic logic [7:0] lanes_of(input logic [3:0] size, input logic [1:0] off);
        return {4'b0000, size} << off;
    endfunction

endpackage

// File: rtl/lsu_seq_if.sv
// Word-addressed data memory port with a req/ack handshake.
interface lsu_seq_if;
    logic        req;
    logic        ack;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  bmask;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output req, addr, we, bmask, wdata, input ack, rdata);
    modport slave  (input req, addr, we, bmask, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Load data extraction: picks the addressed bytes out of {hi,lo}, truncates to
// the access size and sign/zero extends.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [4:0]  mask,
    output logic [31:0] rdata
);
    logic [31:0] word;

    always_comb begin
        word = 32'({hi, lo} >> {off, 3'b000});
        case (mask[3:0])
            MASK_B[3:0]: rdata = {{24{~mask[4] & word[7]}}, word[7:0]};
            MASK_H[3:0]: rdata = {{16{~mask[4] & word[15]}}, word[15:0]};
            default:     rdata = word;
        endcase
    end
endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer between the core and a req/ack word memory.
// Build option LSU_SPLIT_EN: misaligned accesses split into two word transactions;
// otherwise they complete immediately with o_err.
module lsu_seq
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [4:0]  i_mask,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    lsu_seq_if.master   mem
);
    logic [1:0]  state_reg;
    logic        we_reg;
    logic [4:0]  mask_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_val;
    logic [31:0] aligned;
    logic [7:0]  lanes_next;
    logic        start;
    logic        fault;
    logic [4:0]  shift_lo;
    logic [31:0] word_addr;
`ifdef LSU_SPLIT_EN
    logic [7:0]  lanes_reg;
    logic [31:0] hi_reg;
`else
    logic [3:0]  lanes_reg;
    logic        err_reg;
`endif

    assign start      = (state_reg == S_IDLE) && i_req && (i_mask[3:0] != 4'b0000);
    assign lanes_next = lanes_of(i_mask[3:0], i_addr[1:0]);
    assign shift_lo   = {addr_reg[1:0], 3'b000};
    assign word_addr  = {addr_reg[31:2], 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
            we_reg    <= 1'b0;
            mask_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            lo_reg    <= '0;
            lanes_reg <= '0;
`ifdef LSU_SPLIT_EN
            hi_reg    <= '0;
`else
            err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: if (start) begin
                    we_reg    <= i_we;
                    mask_reg  <= i_mask;
                    addr_reg  <= i_addr;
                    wdata_reg <= i_wdata;
`ifdef LSU_SPLIT_EN
                    lanes_reg <= lanes_next;
                    state_reg <= S_ACC0;
`else
                    // A word-crossing access cannot be served; report it without touching memory.
                    lanes_reg <= lanes_next[3:0];
                    err_reg   <= |lanes_next[7:4];
                    state_reg <= (|lanes_next[7:4]) ? S_RESP : S_ACC0;
`endif
                end
                S_ACC0: if (mem.ack) begin
                    lo_reg <= mem.rdata;
`ifdef LSU_SPLIT_EN
                    state_reg <= (|lanes_reg[7:4]) ? S_ACC1 : S_RESP;
`else
                    state_reg <= S_RESP;
`endif
                end
`ifdef LSU_SPLIT_EN
                S_ACC1: if (mem.ack) begin
                    hi_reg    <= mem.rdata;
                    state_reg <= S_RESP;
                end
`endif
                S_RESP:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Memory port is driven only while a transaction is outstanding.
    always_comb begin
        mem.req   = 1'b0;
        mem.addr  = '0;
        mem.we    = 1'b0;
        mem.bmask = '0;
        mem.wdata = '0;
        if (state_reg == S_ACC0) begin
            mem.req   = 1'b1;
            mem.addr  = word_addr;
            mem.we    = we_reg;
            mem.bmask = lanes_reg[3:0];
            mem.wdata = wdata_reg << shift_lo;
        end
`ifdef LSU_SPLIT_EN
        if (state_reg == S_ACC1) begin
            mem.req   = 1'b1;
            mem.addr  = word_addr + 32'd4;
            mem.we    = we_reg;
            mem.bmask = lanes_reg[7:4];
            mem.wdata = wdata_reg >> (6'd32 - {1'b0, shift_lo});
        end
`endif
    end

`ifdef LSU_SPLIT_EN
    assign hi_val = hi_reg;
    assign fault  = 1'b0;
`else
    assign hi_val = 32'd0;
    assign fault  = err_reg;
`endif

    lsu_align u_align (
        .hi    (hi_val),
        .lo    (lo_reg),
        .off   (addr_reg[1:0]),
        .mask  (mask_reg),
        .rdata (aligned)
    );

    assign o_stall = (state_reg == S_ACC0) || (state_reg == S_ACC1) || start;
    assign o_done  = (state_reg == S_RESP);
    assign o_err   = o_done && fault;
    assign o_rdata = (o_done && !we_reg && !fault) ? aligned : 32'd0;

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Load/store sequencer between the single-cycle datapath and the data memory. It accepts one access per request, using the decoder's `o_memWrEnable` and 5-bit `o_mask` plus the ALU address and rs2 data. It drives a word-addressed memory port with a req/ack handshake and stalls the core until the access completes. It aligns store data, extracts and extends load data, and optionally splits misaligned accesses into two word transactions.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  access request from the core; level, held while `o_stall`.
- `i_we`  in  1  1 = store, 0 = load.
- `i_mask`  in  5  bit4 = unsigned load; bits3:0 = size (0001 byte, 0011 half, 1111 word); 00000 = no access.
- `i_addr`  in  32  byte address.
- `i_wdata`  in  32  store data, LSB-justified.
- `o_stall`  out  1  freeze PC/pipeline.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rdata`  out  32  extended load data; valid when `o_done`, 0 otherwise.
- `o_err`  out  1  misaligned fault; valid with `o_done`.
- `o_mem_req`  out  1  memory request.
- `i_mem_ack`  in  1  memory accept/complete, one-cycle pulse.
- `o_mem_addr`  out  32  word-aligned address.
- `o_mem_we`  out  1  write enable.
- `o_mem_bmask`  out  4  byte lane enables.
- `o_mem_wdata`  out  32  lane-aligned store data.
- `i_mem_rdata`  in  32  read word; valid with `i_mem_ack`.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- **IDLE**
  - On `i_req` with `i_mask[3:0]` != 0: latch all inputs.
  - Compute `off = addr[1:0]` and 8-bit `lanes = mask[3:0] << off`.
  - Go to ACC0.
  - `i_req` with mask 00000 is a no-op: no stall, stay in IDLE.
- **ACC0**
  - Drive `o_mem_req=1`, `o_mem_addr = {addr[31:2],2'b00}`, `o_mem_bmask = lanes[3:0]`, `o_mem_wdata = wdata << 8*off`.
  - On ack: capture `lo = i_mem_rdata`.
  - Then go to ACC1 if `lanes[7:4]` != 0, otherwise to RESP.
- **ACC1**
  - Drive `o_mem_addr` = word address + 4 (wraps modulo 2^32), `o_mem_bmask = lanes[7:4]`, `o_mem_wdata = wdata >> 8*(4-off)`.
  - On ack: capture `hi`, go to RESP.
- **RESP**
  - `o_done=1` for one cycle.
  - `o_rdata = ({hi,lo} >> 8*off)[31:0]`, truncated to size, then sign-extended (bit4=0) or zero-extended (bit4=1).
  - Stores: `o_rdata=0`.
  - Bit4 is ignored for word loads and for all stores.
  - Return to IDLE.
- `o_stall = (state==ACC0 | state==ACC1) | (state==IDLE & i_req & mask[3:0]!=0)`. It is combinational and low in RESP, so the core advances in the `o_done` cycle.
- `i_req` outside IDLE is ignored.
- `o_mem_req`, address, mask and data are held stable until ack.

## Timing
- Reset values: state IDLE; every output 0 except `o_stall`, which follows `i_req` per the combinational equation above.
- `i_mem_ack` may assert in the first cycle of `o_mem_req` (zero wait state).
- Aligned access, request at cycle 0:
  - ACC0 at cycle 1; ack at cycle 1 gives `o_done` at cycle 2.
  - Each extra wait cycle adds 1.
- Split access: `o_done` at cycle 3 minimum.
- `i_mem_ack` while `o_mem_req`=0 is ignored.
- `i_rst` in any state: IDLE next cycle, `o_mem_req` drops, no `o_done`; the in-flight memory transaction is abandoned.

## Configuration
- `LSU_SPLIT_EN` defined: misaligned accesses use ACC1 as above; `o_err` is tied 0.
- `LSU_SPLIT_EN` undefined: when `lanes[7:4]` != 0, IDLE goes directly to RESP.
  - No memory request is issued.
  - `o_err=1` and `o_rdata=0` with `o_done`.
  - The ACC1 state and `hi` register are omitted.

## Structure
- `lsu_pkg`:
  - State enum.
  - Mask constants `MASK_B`=5'b00001, `MASK_H`=5'b00011, `MASK_W`=5'b01111, `MASK_BU`=5'b10001, `MASK_HU`=5'b10011.
  - Shared with the decoder.
- Sub-module `lsu_align`: combinational extraction of `{hi,lo}`, size truncation and extension.

## Test plan
- **SW, aligned:** addr 0x100, data 0xDEADBEEF, mask 01111, zero-wait → one req (0x100, bmask 1111, wdata 0xDEADBEEF); `o_done` at cycle 2; `o_stall` high at cycles 0–1.
- **LB/LBU:** addr 0x103, memory returns 0x80123456 → LB `o_rdata` 0xFFFFFF80; LBU (mask 10001) 0x00000080.
- **SH, misaligned:** addr 0x203, data 0x1234.
  - With `LSU_SPLIT_EN`: req (0x200, 1000, 0x34000000), then (0x204, 0001, 0x00000012); `o_done` at cycle 3.
  - Without: no req; `o_err=1` at cycle 1.
- **LW, misaligned, 3 wait states each:** addr 0x102, [0x100]=0xAABBCCDD, [0x104]=0x11223344 → `o_rdata` 0x3344AABB; `o_done` at cycle 9.
- **Reset in ACC1:** `i_rst` pulsed while waiting in ACC1 → next cycle `o_mem_req=0`, `o_stall=0`, no `o_done`; a subsequent aligned LW completes normally.
- **Mask 00000:** `i_req` with mask 00000 → `o_stall=0`, no `o_mem_req`, no `o_done`.
